// File: rtl/pedal_sensor_cond.sv
// Pedal sensor conditioning: synchronizes the crank sensor, measures cadence per
// fixed window and keeps an exponential average of torque sampled on each crank edge.
module pedal_sensor_cond #(
    parameter int FAST_SIM = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cadence_raw,
    input  logic [11:0] torque,
    output logic [4:0]  cadence,
    output logic        not_pedaling,
    output logic [11:0] avg_torque,
    output logic        cad_rise
);

    localparam int WIN_W = (FAST_SIM != 0) ? 12 : 24;
    localparam logic [4:0] EDGE_MAX = 5'd31;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_sync3;
    logic [WIN_W-1:0] r_win_cnt;
    logic [4:0]       r_edge_cnt;
    logic [4:0]       r_cadence;
    logic             r_not_pedaling;
    logic [16:0]      r_accum;
    logic             r_seeded;

    logic             w_cad_rise;
    logic             w_win_end;
    logic [4:0]       w_edge_sum;
    logic [16:0]      w_accum_next;

    // Two-flop synchronizer on the asynchronous sensor, third flop for edge detect.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= cadence_raw;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_cad_rise = r_sync2 & ~r_sync3;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_win_cnt <= '0;
        end else begin
            r_win_cnt <= r_win_cnt + WIN_W'(1);
        end
    end

    assign w_win_end = &r_win_cnt;

    // Count including the current cycle's edge, so a rise on the window-end cycle
    // lands in this window's result rather than the next one.
    always_comb begin
        w_edge_sum = r_edge_cnt;
        if (w_cad_rise && (r_edge_cnt != EDGE_MAX)) begin
            w_edge_sum = r_edge_cnt + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_edge_cnt     <= '0;
            r_cadence      <= '0;
            r_not_pedaling <= 1'b1;
        end else if (w_win_end) begin
            r_edge_cnt     <= '0;
            r_cadence      <= w_edge_sum;
            r_not_pedaling <= (w_edge_sum < 5'd2);
        end else begin
            r_edge_cnt     <= w_edge_sum;
        end
    end

    // First edge seeds the filter directly; later edges apply a 1/32 leak.
    always_comb begin
        w_accum_next = {torque, 5'b0};
        if (r_seeded) begin
            w_accum_next = r_accum - (r_accum >> 5) + {5'b0, torque};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_accum  <= '0;
            r_seeded <= 1'b0;
        end else if (w_cad_rise) begin
            r_accum  <= w_accum_next;
            r_seeded <= 1'b1;
        end
    end

    assign cadence      = r_cadence;
    assign not_pedaling = r_not_pedaling;
    assign avg_torque   = r_accum[16:5];
    assign cad_rise     = w_cad_rise;

endmodule

// File: tb/tb_pedal_sensor_cond.sv
// Directed bench for pedal_sensor_cond with the short window (FAST_SIM=1).
module tb_pedal_sensor_cond;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cadence_raw;
    logic [11:0] torque;
    logic [4:0]  cadence;
    logic        not_pedaling;
    logic [11:0] avg_torque;
    logic        cad_rise;

    int checks   = 0;
    int failures = 0;
    int rise_cyc = 0;
    logic [11:0] tb_win = 12'd0;

    pedal_sensor_cond #(.FAST_SIM(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cadence_raw  (cadence_raw),
        .torque       (torque),
        .cadence      (cadence),
        .not_pedaling (not_pedaling),
        .avg_torque   (avg_torque),
        .cad_rise     (cad_rise)
    );

    always #5 clk = ~clk;

    // Window position reference: window end is the edge taken while this reads 4095.
    always @(posedge clk) begin
        if (rst_n !== 1'b1) tb_win <= 12'd0;
        else                tb_win <= tb_win + 12'd1;
    end

    always @(negedge clk) begin
        if (cad_rise === 1'b1) rise_cyc++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int hi, input int lo);
        cadence_raw = 1'b1;
        tick(hi);
        cadence_raw = 1'b0;
        tick(lo);
    endtask

    task automatic wait_window_end();
        int k = 0;
        while (tb_win != 12'hFFF && k < 5000) begin
            tick(1);
            k++;
        end
        if (k >= 5000) begin
            checks++; failures++;
            $display("FAIL window_wait timed out tb_win=%0d", tb_win);
        end
        tick(1);
    endtask

    task automatic test_reset();
        cadence_raw = 1'b0;
        torque      = 12'h000;
        rst_n       = 1'b0;
        tick(5);
        checks++; if (cadence !== 5'd0) begin failures++; $display("FAIL rst_cadence got=%0d exp=0", cadence); end
        checks++; if (not_pedaling !== 1'b1) begin failures++; $display("FAIL rst_not_pedaling got=%b exp=1", not_pedaling); end
        checks++; if (avg_torque !== 12'h000) begin failures++; $display("FAIL rst_avg got=%h exp=000", avg_torque); end
        checks++; if (cad_rise !== 1'b0) begin failures++; $display("FAIL rst_cad_rise got=%b exp=0", cad_rise); end
        rst_n = 1'b1;
        tick(1);
        checks++; if (cadence !== 5'd0 || not_pedaling !== 1'b1) begin failures++; $display("FAIL rst_release cad=%0d np=%b exp 0/1", cadence, not_pedaling); end
        wait_window_end();
        checks++; if (cadence !== 5'd0) begin failures++; $display("FAIL rst_win1_cadence got=%0d exp=0", cadence); end
        checks++; if (not_pedaling !== 1'b1) begin failures++; $display("FAIL rst_win1_np got=%b exp=1", not_pedaling); end
        $display("test_reset done checks=%0d", checks);
    endtask

    task automatic test_averaging();
        torque = 12'h800;
        pulse(4, 10);
        checks++; if (avg_torque !== 12'h800) begin failures++; $display("FAIL avg_seed got=%h exp=800", avg_torque); end
        torque = 12'h123;
        tick(20);
        checks++; if (avg_torque !== 12'h800) begin failures++; $display("FAIL avg_hold1 got=%h exp=800", avg_torque); end
        torque = 12'h000;
        pulse(4, 10);
        checks++; if (avg_torque !== 12'h7C0) begin failures++; $display("FAIL avg_second got=%h exp=7c0", avg_torque); end
        torque = 12'hFFF;
        pulse(4, 10);
        checks++; if (avg_torque !== 12'h801) begin failures++; $display("FAIL avg_third got=%h exp=801", avg_torque); end
        torque = 12'hABC;
        tick(30);
        checks++; if (avg_torque !== 12'h801) begin failures++; $display("FAIL avg_hold2 got=%h exp=801", avg_torque); end
        wait_window_end();
        checks++; if (cadence !== 5'd3 || not_pedaling !== 1'b0) begin failures++; $display("FAIL avg_window cad=%0d np=%b exp 3/0", cadence, not_pedaling); end
        $display("test_averaging done checks=%0d", checks);
    endtask

    task automatic test_nominal();
        int n0 = rise_cyc;
        cadence_raw = 1'b1;
        tick(1);
        checks++; if (cad_rise !== 1'b0) begin failures++; $display("FAIL lat_c1 got=%b exp=0", cad_rise); end
        tick(1);
        checks++; if (cad_rise !== 1'b1) begin failures++; $display("FAIL lat_c2 got=%b exp=1", cad_rise); end
        tick(1);
        checks++; if (cad_rise !== 1'b0) begin failures++; $display("FAIL lat_c3 got=%b exp=0", cad_rise); end
        tick(17);
        cadence_raw = 1'b0;
        tick(200);
        repeat (4) pulse(20, 200);
        checks++; if (rise_cyc - n0 !== 5) begin failures++; $display("FAIL nom_rise_count got=%0d exp=5", rise_cyc - n0); end
        checks++; if (cadence !== 5'd3) begin failures++; $display("FAIL nom_held_prev got=%0d exp=3", cadence); end
        wait_window_end();
        checks++; if (cadence !== 5'd5) begin failures++; $display("FAIL nom_cadence got=%0d exp=5", cadence); end
        checks++; if (not_pedaling !== 1'b0) begin failures++; $display("FAIL nom_np got=%b exp=0", not_pedaling); end
        tick(1000);
        checks++; if (cadence !== 5'd5 || not_pedaling !== 1'b0) begin failures++; $display("FAIL nom_hold cad=%0d np=%b exp 5/0", cadence, not_pedaling); end
        wait_window_end();
        checks++; if (cadence !== 5'd0 || not_pedaling !== 1'b1) begin failures++; $display("FAIL nom_idle cad=%0d np=%b exp 0/1", cadence, not_pedaling); end
        $display("test_nominal done checks=%0d", checks);
    endtask

    task automatic test_saturation();
        int n0 = rise_cyc;
        repeat (40) pulse(3, 3);
        checks++; if (rise_cyc - n0 !== 40) begin failures++; $display("FAIL sat_rise_count got=%0d exp=40", rise_cyc - n0); end
        wait_window_end();
        checks++; if (cadence !== 5'd31 || not_pedaling !== 1'b0) begin failures++; $display("FAIL sat_cadence cad=%0d np=%b exp 31/0", cadence, not_pedaling); end
        pulse(3, 3);
        wait_window_end();
        checks++; if (cadence !== 5'd1 || not_pedaling !== 1'b1) begin failures++; $display("FAIL thr_one cad=%0d np=%b exp 1/1", cadence, not_pedaling); end
        repeat (2) pulse(3, 3);
        wait_window_end();
        checks++; if (cadence !== 5'd2 || not_pedaling !== 1'b0) begin failures++; $display("FAIL thr_two cad=%0d np=%b exp 2/0", cadence, not_pedaling); end
        $display("test_saturation done checks=%0d", checks);
    endtask

    task automatic test_boundary();
        int k = 0;
        repeat (2) pulse(20, 200);
        while (tb_win != 12'd4093 && k < 5000) begin
            tick(1);
            k++;
        end
        if (k >= 5000) begin
            checks++; failures++;
            $display("FAIL bnd_align timed out tb_win=%0d", tb_win);
        end
        cadence_raw = 1'b1;
        tick(2);
        checks++; if (cad_rise !== 1'b1) begin failures++; $display("FAIL bnd_rise_at_end got=%b exp=1", cad_rise); end
        tick(1);
        checks++; if (cadence !== 5'd3 || not_pedaling !== 1'b0) begin failures++; $display("FAIL bnd_cadence cad=%0d np=%b exp 3/0", cadence, not_pedaling); end
        tick(17);
        cadence_raw = 1'b0;
        wait_window_end();
        checks++; if (cadence !== 5'd0 || not_pedaling !== 1'b1) begin failures++; $display("FAIL bnd_next cad=%0d np=%b exp 0/1", cadence, not_pedaling); end
        $display("test_boundary done checks=%0d", checks);
    endtask

    task automatic test_reset_mid();
        torque = 12'h100;
        repeat (3) pulse(20, 100);
        rst_n = 1'b0;
        tick(5);
        checks++; if (avg_torque !== 12'h000 || cadence !== 5'd0 || not_pedaling !== 1'b1) begin failures++; $display("FAIL mid_rst avg=%h cad=%0d np=%b exp 000/0/1", avg_torque, cadence, not_pedaling); end
        rst_n  = 1'b1;
        torque = 12'h200;
        pulse(20, 100);
        checks++; if (avg_torque !== 12'h200) begin failures++; $display("FAIL mid_reseed got=%h exp=200", avg_torque); end
        torque = 12'h000;
        pulse(20, 100);
        checks++; if (avg_torque !== 12'h1F0) begin failures++; $display("FAIL mid_avg2 got=%h exp=1f0", avg_torque); end
        wait_window_end();
        checks++; if (cadence !== 5'd2 || not_pedaling !== 1'b0) begin failures++; $display("FAIL mid_cadence cad=%0d np=%b exp 2/0", cadence, not_pedaling); end
        $display("test_reset_mid done checks=%0d", checks);
    endtask

    initial begin
        rst_n       = 1'b0;
        cadence_raw = 1'b0;
        torque      = 12'h000;
        test_reset();
        test_averaging();
        test_nominal();
        test_saturation();
        test_boundary();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
